// File: rtl/filtro_defs.sv
// Shared definitions for the recursive filter arithmetic: default Q7.14 format,
// saturation limits common to the multiplier and divider, and divider FSM states.
package filtro_defs;

    localparam int WIDTH_DEF     = 22;
    localparam int PRESICION_DEF = 14;

    // Symmetric limits: the most negative code is never produced.
    localparam logic signed [WIDTH_DEF-1:0] MAXIMO = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    localparam logic signed [WIDTH_DEF-1:0] MINIMO = {1'b1, {(WIDTH_DEF-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } estado_t;

endpackage

// File: rtl/paso_division.sv
// One restoring-division step on unsigned magnitudes: shift the next numerator
// bit into the remainder and subtract the divisor when it fits.
module paso_division #(
    parameter int W = 22
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] div,
    input  logic         bit_in,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0]   desplazado;
    logic [W-1:0] resta;

    always_comb begin
        desplazado = {rem, bit_in};
        q_bit      = (desplazado >= {1'b0, div});
        // When the divisor fits, the difference is below div and fits in W bits.
        resta      = desplazado[W-1:0] - div;
        rem_out    = q_bit ? resta : desplazado[W-1:0];
    end

endmodule

// File: rtl/divisor_filtro.sv
// Sequential saturating signed fixed-point divider Y = A/B (one quotient bit per clock).
// Optional macro DIV_ROUND_EN: one extra iteration for round-half-away-from-zero.
module divisor_filtro
    import filtro_defs::*;
#(
    parameter int Width     = WIDTH_DEF,
    parameter int Presicion = PRESICION_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [Width-1:0] A,
    input  logic signed [Width-1:0] B,
    output logic signed [Width-1:0] Y,
    output logic                    busy,
    output logic                    done,
    output logic                    div_zero
);

    localparam int Magnitud = Width - Presicion - 1;
`ifdef DIV_ROUND_EN
    localparam int NI = Width + Presicion + 1;
`else
    localparam int NI = Width + Presicion;
`endif
    localparam int CW = $clog2(NI);

    localparam logic [Width-1:0] maximo = {1'b0, {(Magnitud + Presicion){1'b1}}};
    localparam logic [Width-1:0] minimo = {1'b1, {(Width - 2){1'b0}}, 1'b1};

    estado_t         estado_reg;
    logic [CW-1:0]   cnt_reg;
    logic [NI-1:0]   num_reg;
    logic [Width-1:0] den_reg;
    logic [Width-1:0] rem_reg;
    logic [NI-1:0]   quo_reg;
    logic            sign_reg;
    logic            a_zero_reg;
    logic            b_zero_reg;

    logic [Width-1:0] a_mag;
    logic [Width-1:0] b_mag;
    logic [Width-1:0] rem_next;
    logic             q_bit;
    logic [NI-1:0]    quo_final;
    logic [NI-1:0]    mag;
    logic [Width-1:0] y_next;

    // Magnitudes as unsigned: -2^(W-1) maps to 2^(W-1) without overflow.
    always_comb begin
        a_mag = A[Width-1] ? Width'(-A) : A;
        b_mag = B[Width-1] ? Width'(-B) : B;
    end

    paso_division #(.W(Width)) u_paso (
        .rem     (rem_reg),
        .div     (den_reg),
        .bit_in  (num_reg[NI-1]),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        quo_final = {quo_reg[NI-2:0], q_bit};
`ifdef DIV_ROUND_EN
        mag = (quo_final >> 1) + NI'(quo_final[0]);
`else
        mag = quo_final;
`endif
        if (a_zero_reg)
            y_next = '0;
        else if (b_zero_reg || (mag > NI'(maximo)))
            y_next = sign_reg ? minimo : maximo;
        else
            y_next = sign_reg ? Width'(-mag[Width-1:0]) : mag[Width-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_reg <= IDLE;
            cnt_reg    <= '0;
            num_reg    <= '0;
            den_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            sign_reg   <= 1'b0;
            a_zero_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            Y          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            case (estado_reg)
                IDLE: begin
                    if (start) begin
                        num_reg    <= {a_mag, {(NI - Width){1'b0}}};
                        den_reg    <= b_mag;
                        rem_reg    <= '0;
                        quo_reg    <= '0;
                        cnt_reg    <= '0;
                        sign_reg   <= A[Width-1] ^ B[Width-1];
                        a_zero_reg <= (A == '0);
                        b_zero_reg <= (B == '0);
                        busy       <= 1'b1;
                        estado_reg <= CALC;
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_final;
                    num_reg <= {num_reg[NI-2:0], 1'b0};
                    cnt_reg <= cnt_reg + 1'b1;
                    // Result is registered on the last step so done lands in the FIN cycle.
                    if (cnt_reg == CW'(NI - 1)) begin
                        Y          <= y_next;
                        div_zero   <= b_zero_reg;
                        done       <= 1'b1;
                        estado_reg <= FIN;
                    end
                end
                FIN: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    estado_reg <= IDLE;
                end
                default: estado_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_filtro.sv
// Self-checking bench for divisor_filtro: directed Q7.14 cases, random operands,
// busy/start interaction, mid-operation reset and back-to-back operation.
module tb_divisor_filtro;

    localparam int W = 22;
    localparam int P = 14;
`ifdef DIV_ROUND_EN
    localparam int LAT   = W + P + 2;
    localparam bit ROUND = 1'b1;
`else
    localparam int LAT   = W + P + 1;
    localparam bit ROUND = 1'b0;
`endif
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [W-1:0] A;
    logic signed [W-1:0] B;
    logic signed [W-1:0] Y;
    logic                busy;
    logic                done;
    logic                div_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divisor_filtro dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .Y        (Y),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    // Reference: exact integer division of the scaled magnitudes, then sign/saturation.
    function automatic longint model_y(input longint a, input longint b);
        longint ma, mb, q;
        if (a == 0) return 0;
        if (b == 0) return (a > 0) ? MAXV : -MAXV;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        if (ROUND) q = (((ma << (P + 1)) / mb) + 1) / 2;
        else       q = (ma << P) / mb;
        if (q > MAXV) q = MAXV;
        return ((a < 0) != (b < 0)) ? -q : q;
    endfunction

    function automatic longint rand_operand();
        int sel;
        logic signed [W-1:0] v;
        sel = $urandom_range(0, 9);
        v = W'($urandom);
        if (sel == 0) v = '0;
        else if (sel < 4) v = W'($signed($urandom_range(0, 131071)) - 65536);
        else if (sel == 4) v = W'(1);
        return longint'(v);
    endfunction

    task automatic run_op(input longint a, input longint b, output longint y,
                          output bit dz, output int cyc, output bit busy_ok);
        @(negedge clk);
        A = W'(a);
        B = W'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < LAT + 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (!busy) busy_ok = 1'b0;
        y  = longint'(Y);
        dz = div_zero;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (Y !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: Y=%0d busy=%b done=%b div_zero=%b required 0/0/0/0",
                     Y, busy, done, div_zero);
        end
        reset = 1'b0;
        $display("reset: Y=%0d busy=%b done=%b div_zero=%b", Y, busy, done, div_zero);
    endtask

    task automatic test_vectors();
        longint ta [10] = '{24576, -24576, -24576, 1048576, -1048576, 16384, -16384, 0, 32768, -2097152};
        longint tb [10] = '{8192,   8192,  -8192,  1,       1,        0,     0,      0, 49152, -2097152};
        longint y, exp_y;
        bit dz, bok;
        int cyc;
        for (int i = 0; i < 10; i++) begin
            run_op(ta[i], tb[i], y, dz, cyc, bok);
            exp_y = model_y(ta[i], tb[i]);
            $display("vector %0d: A=%0d B=%0d Y=%0d div_zero=%b cycles=%0d", i, ta[i], tb[i], y, dz, cyc);
            checks++;
            if (y !== exp_y || dz !== (tb[i] == 0)) begin
                failures++;
                $display("FAIL vector_%0d: Y=%0d div_zero=%b required Y=%0d div_zero=%b",
                         i, y, dz, exp_y, (tb[i] == 0));
            end
            checks++;
            if (cyc !== LAT || !bok) begin
                failures++;
                $display("FAIL vector_%0d_timing: latency=%0d busy_ok=%b required latency=%0d busy_ok=1",
                         i, cyc, bok, LAT);
            end
        end
    endtask

    task automatic test_random();
        longint a, b, y, exp_y, held;
        bit dz, bok;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            a = rand_operand();
            b = rand_operand();
            run_op(a, b, y, dz, cyc, bok);
            exp_y = model_y(a, b);
            $display("random %0d: A=%0d B=%0d Y=%0d div_zero=%b cycles=%0d", i, a, b, y, dz, cyc);
            checks++;
            if (y !== exp_y || dz !== (b == 0) || cyc !== LAT || !bok) begin
                failures++;
                $display("FAIL random_%0d: Y=%0d dz=%b lat=%0d busy_ok=%b required Y=%0d dz=%b lat=%0d",
                         i, y, dz, cyc, bok, exp_y, (b == 0), LAT);
            end
            held = y;
            @(negedge clk);
            checks++;
            if (longint'(Y) !== held || done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL random_%0d_hold: Y=%0d done=%b busy=%b required Y=%0d done=0 busy=0",
                         i, Y, done, busy, held);
            end
        end
    endtask

    task automatic test_busy_ignore();
        longint exp_y;
        int cyc;
        exp_y = model_y(24576, 8192);
        @(negedge clk);
        A = W'(24576);
        B = W'(8192);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < LAT + 20) begin
            if (cyc == 5) begin
                A = W'(-100000);
                B = W'(3);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        $display("busy_ignore: Y=%0d cycles=%0d", Y, cyc);
        checks++;
        if (longint'(Y) !== exp_y || cyc !== LAT) begin
            failures++;
            $display("FAIL busy_ignore: Y=%0d latency=%0d required Y=%0d latency=%0d",
                     Y, cyc, exp_y, LAT);
        end
    endtask

    task automatic test_reset_abort();
        longint y, exp_y;
        bit dz, bok, saw_done;
        int cyc;
        @(negedge clk);
        A = W'(32768);
        B = W'(49152);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (Y !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_state: Y=%0d busy=%b done=%b required 0/0/0", Y, busy, done);
        end
        saw_done = 1'b0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_no_done: done_seen=%b required 0", saw_done);
        end
        $display("reset_abort: done_seen=%b Y=%0d busy=%b", saw_done, Y, busy);
        run_op(-32768, 49152, y, dz, cyc, bok);
        exp_y = model_y(-32768, 49152);
        $display("after_abort: Y=%0d cycles=%0d", y, cyc);
        checks++;
        if (y !== exp_y || cyc !== LAT || !bok) begin
            failures++;
            $display("FAIL after_abort: Y=%0d latency=%0d required Y=%0d latency=%0d",
                     y, cyc, exp_y, LAT);
        end
    endtask

    task automatic test_back_to_back();
        longint a, b, y, exp_y;
        bit dz, bok;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            a = rand_operand();
            b = rand_operand();
            run_op(a, b, y, dz, cyc, bok);
            exp_y = model_y(a, b);
            $display("back_to_back %0d: A=%0d B=%0d Y=%0d cycles=%0d", i, a, b, y, cyc);
            checks++;
            if (y !== exp_y || dz !== (b == 0) || cyc !== LAT || !bok) begin
                failures++;
                $display("FAIL back_to_back_%0d: Y=%0d dz=%b lat=%0d required Y=%0d dz=%b lat=%0d",
                         i, y, dz, cyc, exp_y, (b == 0), LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
